// File: rtl/m32_vram_pkg.sv
// rtl/m32_vram_pkg.sv - shared types and defaults for the VRAM arbiter slice
package m32_vram_pkg;

  localparam int VRAM_ADDR_W     = 15;
  localparam int VRAM_DATA_W     = 32;
  localparam int VRAM_WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT
  } rd_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_CPURD,
    GNT_DRAIN
  } gnt_t;

endpackage

// File: rtl/m32_vram_wbuf.sv
// rtl/m32_vram_wbuf.sv - posted-write FIFO with youngest-match load lookup
module m32_vram_wbuf
  import m32_vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = VRAM_WBUF_DEPTH
) (
  input  logic              coreClk,
  input  logic              coreRst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge coreClk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge coreClk or negedge coreRst) begin
    if (!coreRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addr_mem[rd_ptr + PTR_W'(i)] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[rd_ptr + PTR_W'(i)];
      end
    end
  end

endmodule

// File: rtl/m32_vram_arbiter.sv
// rtl/m32_vram_arbiter.sv - shares single-port VRAM between CPU loads/stores and VGA scan-out
module m32_vram_arbiter
  import m32_vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int WBUF_DEPTH = VRAM_WBUF_DEPTH
) (
  input  logic              coreClk,
  input  logic              coreRst,
  input  logic              cpuWr,
  input  logic              cpuRd,
  input  logic [31:0]       cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuStall,
  input  logic              vgaReq,
  input  logic [ADDR_W-1:0] vgaAddr,
  output logic              vgaGnt,
  output logic              vgaValid,
  output logic [DATA_W-1:0] vgaRdata,
  output logic              vramEn,
  output logic              vramWe,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramWdata,
  input  logic [DATA_W-1:0] vramRdata
);

  rd_state_t         rd_state;
  rd_state_t         rd_next;
  gnt_t              gnt;
  logic              lost_q;
  logic              pend_rd_q;
  logic              vga_valid_q;

  logic [ADDR_W-1:0] cpu_waddr;
  logic              unused_addr_bits;
  logic              wr_eff;
  logic              rd_active;
  logic              wb_push;
  logic              wb_pop;
  logic              wb_full;
  logic              wb_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign cpu_waddr        = cpuAddr[ADDR_W+1:2];
  assign unused_addr_bits = ^{cpuAddr[31:ADDR_W+2], cpuAddr[1:0]};

  // A paired store+load posts the store once; the held load then forwards from it.
  assign wr_eff    = coreRst && cpuWr && !pend_rd_q;
  assign rd_active = coreRst && cpuRd && !wr_eff;
  assign wb_push   = wr_eff && !wb_full;

  m32_vram_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .coreClk     (coreClk),
    .coreRst     (coreRst),
    .push        (wb_push),
    .push_addr   (cpu_waddr),
    .push_data   (cpuWdata),
    .pop         (wb_pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (wb_full),
    .empty       (wb_empty),
    .lookup_addr (cpu_waddr),
    .lookup_hit  (fwd_hit),
    .lookup_data (fwd_data)
  );

  // Two guards keep VGA priority from starving a full buffer or a retried load.
  always_comb begin
    gnt = GNT_NONE;
    if (!coreRst)                                    gnt = GNT_NONE;
    else if (wb_full)                                gnt = GNT_DRAIN;
    else if (lost_q && rd_state == RD_REQ && cpuRd)  gnt = GNT_CPURD;
    else if (vgaReq)                                 gnt = GNT_VGA;
    else if (rd_state == RD_REQ && cpuRd)            gnt = GNT_CPURD;
    else if (!wb_empty)                              gnt = GNT_DRAIN;
  end

  always_comb begin
    vramEn    = 1'b0;
    vramWe    = 1'b0;
    vramAddr  = '0;
    vramWdata = '0;
    vgaGnt    = 1'b0;
    wb_pop    = 1'b0;
    case (gnt)
      GNT_VGA: begin
        vramEn   = 1'b1;
        vramAddr = vgaAddr;
        vgaGnt   = 1'b1;
      end
      GNT_CPURD: begin
        vramEn   = 1'b1;
        vramAddr = cpu_waddr;
      end
      GNT_DRAIN: begin
        vramEn    = 1'b1;
        vramWe    = 1'b1;
        vramAddr  = head_addr;
        vramWdata = head_data;
        wb_pop    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge coreClk or negedge coreRst) begin
    if (!coreRst) begin
      rd_state    <= RD_IDLE;
      lost_q      <= 1'b0;
      pend_rd_q   <= 1'b0;
      vga_valid_q <= 1'b0;
    end else begin
      rd_state    <= rd_next;
      lost_q      <= (rd_state == RD_REQ) && cpuRd && (gnt != GNT_CPURD);
      pend_rd_q   <= cpuRd && cpuStall && (pend_rd_q || wb_push);
      vga_valid_q <= (gnt == GNT_VGA);
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_active && !fwd_hit) rd_next = RD_REQ;
      RD_REQ: begin
        if (!cpuRd)                 rd_next = RD_IDLE;
        else if (gnt == GNT_CPURD)  rd_next = RD_WAIT;
      end
      RD_WAIT: rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    cpuStall = 1'b0;
    cpuRdata = '0;
    if (wr_eff) begin
      cpuStall = wb_full || cpuRd;
    end else if (rd_active) begin
      case (rd_state)
        RD_IDLE: begin
          if (fwd_hit) cpuRdata = fwd_data;
          else         cpuStall = 1'b1;
        end
        RD_REQ:  cpuStall = 1'b1;
        RD_WAIT: cpuRdata = vramRdata;
        default: cpuStall = 1'b0;
      endcase
    end
  end

  assign vgaValid = vga_valid_q;
  assign vgaRdata = vga_valid_q ? vramRdata : '0;

endmodule

// File: tb/tb_m32_vram_arbiter.sv
// tb/tb_m32_vram_arbiter.sv - directed self-checking bench for m32_vram_arbiter
module tb_m32_vram_arbiter;

  logic        coreClk;
  logic        coreRst;
  logic        cpuWr;
  logic        cpuRd;
  logic [31:0] cpuAddr;
  logic [31:0] cpuWdata;
  logic [31:0] cpuRdata;
  logic        cpuStall;
  logic        vgaReq;
  logic [14:0] vgaAddr;
  logic        vgaGnt;
  logic        vgaValid;
  logic [31:0] vgaRdata;
  logic        vramEn;
  logic        vramWe;
  logic [14:0] vramAddr;
  logic [31:0] vramWdata;
  logic [31:0] vramRdata;

  int n_chk;
  int n_fail;

  m32_vram_arbiter dut (
    .coreClk   (coreClk),
    .coreRst   (coreRst),
    .cpuWr     (cpuWr),
    .cpuRd     (cpuRd),
    .cpuAddr   (cpuAddr),
    .cpuWdata  (cpuWdata),
    .cpuRdata  (cpuRdata),
    .cpuStall  (cpuStall),
    .vgaReq    (vgaReq),
    .vgaAddr   (vgaAddr),
    .vgaGnt    (vgaGnt),
    .vgaValid  (vgaValid),
    .vgaRdata  (vgaRdata),
    .vramEn    (vramEn),
    .vramWe    (vramWe),
    .vramAddr  (vramAddr),
    .vramWdata (vramWdata),
    .vramRdata (vramRdata)
  );

  initial coreClk = 1'b0;
  always #5 coreClk = ~coreClk;

  // RAM contents for addresses the bench reads; never written by the tests.
  function automatic logic [31:0] init_word(input logic [14:0] a);
    case (a)
      15'h030: init_word = 32'h55;
      15'h031: init_word = 32'h66;
      15'h100: init_word = 32'h09;
      default: init_word = {17'h0, a};
    endcase
  endfunction

  always @(posedge coreClk) begin
    if (vramEn && !vramWe) vramRdata <= init_word(vramAddr);
  end

  task automatic idle_inputs();
    cpuWr = 1'b0; cpuRd = 1'b0; cpuAddr = '0; cpuWdata = '0;
    vgaReq = 1'b0; vgaAddr = '0;
  endtask

  task automatic do_reset();
    coreRst = 1'b0;
    idle_inputs();
    @(negedge coreClk);
    @(negedge coreClk);
    coreRst = 1'b1;
  endtask

  task automatic test_reset();
    coreRst = 1'b0;
    idle_inputs();
    vgaReq = 1'b1; cpuRd = 1'b1; cpuAddr = 32'h40;
    #2;
    n_chk++; if (vramEn !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %0b want 0", vramEn); end
    n_chk++; if (vgaGnt !== 1'b0) begin n_fail++; $display("FAIL rst_vgagnt: got %0b want 0", vgaGnt); end
    n_chk++; if (cpuStall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", cpuStall); end
    n_chk++; if (vgaValid !== 1'b0) begin n_fail++; $display("FAIL rst_vgavalid: got %0b want 0", vgaValid); end
    n_chk++; if (cpuRdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %0h want 0", cpuRdata); end
    @(negedge coreClk);
    coreRst = 1'b1;
    idle_inputs();
    #2;
    n_chk++; if (vramEn !== 1'b0) begin n_fail++; $display("FAIL rst_empty_nodrain: got %0b want 0", vramEn); end
    @(negedge coreClk);
  endtask

  task automatic test_post_drain();
    do_reset();
    cpuWr = 1'b1; cpuAddr = 32'hC000_0010; cpuWdata = 32'hDEAD_BEEF;
    #2;
    n_chk++; if (cpuStall !== 1'b0) begin n_fail++; $display("FAIL post_stall: got %0b want 0", cpuStall); end
    n_chk++; if (vramEn !== 1'b0) begin n_fail++; $display("FAIL post_empty_en: got %0b want 0", vramEn); end
    @(negedge coreClk);
    cpuWr = 1'b0;
    #2;
    n_chk++; if (vramWe !== 1'b1) begin n_fail++; $display("FAIL post_drain_we: got %0b want 1", vramWe); end
    n_chk++; if (vramAddr !== 15'd4) begin n_fail++; $display("FAIL post_drain_addr: got %0h want 4", vramAddr); end
    n_chk++; if (vramWdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL post_drain_data: got %0h want deadbeef", vramWdata); end
    @(negedge coreClk);
    #2;
    n_chk++; if (vramEn !== 1'b0) begin n_fail++; $display("FAIL post_after_empty: got %0b want 0", vramEn); end
    @(negedge coreClk);
  endtask

  task automatic test_full_buffer();
    do_reset();
    vgaReq = 1'b1; vgaAddr = 15'h100;
    for (int i = 0; i < 4; i++) begin
      cpuWr = 1'b1; cpuAddr = 32'h40 + 32'(4 * i); cpuWdata = 32'hA0 + 32'(i);
      #2;
      n_chk++; if (cpuStall !== 1'b0) begin n_fail++; $display("FAIL full_fill_stall[%0d]: got %0b want 0", i, cpuStall); end
      n_chk++; if (vgaGnt !== 1'b1) begin n_fail++; $display("FAIL full_fill_vga[%0d]: got %0b want 1", i, vgaGnt); end
      @(negedge coreClk);
    end
    cpuAddr = 32'h50; cpuWdata = 32'hA4;
    #2;
    n_chk++; if (cpuStall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %0b want 1", cpuStall); end
    n_chk++; if (vgaGnt !== 1'b0) begin n_fail++; $display("FAIL full_vga_denied: got %0b want 0", vgaGnt); end
    n_chk++; if (vramWe !== 1'b1) begin n_fail++; $display("FAIL full_forced_we: got %0b want 1", vramWe); end
    n_chk++; if (vramAddr !== 15'h10) begin n_fail++; $display("FAIL full_forced_addr: got %0h want 10", vramAddr); end
    n_chk++; if (vramWdata !== 32'hA0) begin n_fail++; $display("FAIL full_forced_data: got %0h want a0", vramWdata); end
    @(negedge coreClk);
    #2;
    n_chk++; if (cpuStall !== 1'b0) begin n_fail++; $display("FAIL full_accept_stall: got %0b want 0", cpuStall); end
    n_chk++; if (vgaGnt !== 1'b1) begin n_fail++; $display("FAIL full_accept_vga: got %0b want 1", vgaGnt); end
    @(negedge coreClk);
    idle_inputs();
    for (int i = 1; i < 5; i++) begin
      #2;
      n_chk++; if (vramWe !== 1'b1 || vramAddr !== 15'(16 + i) || vramWdata !== 32'hA0 + 32'(i)) begin
        n_fail++; $display("FAIL full_drain_order[%0d]: got we=%0b addr=%0h data=%0h want we=1 addr=%0h data=%0h",
                           i, vramWe, vramAddr, vramWdata, 16 + i, 32'hA0 + 32'(i));
      end
      @(negedge coreClk);
    end
    #2;
    n_chk++; if (vramEn !== 1'b0) begin n_fail++; $display("FAIL full_drained_empty: got %0b want 0", vramEn); end
    @(negedge coreClk);
  endtask

  task automatic test_forwarding();
    do_reset();
    vgaReq = 1'b1; vgaAddr = 15'h7;
    cpuWr = 1'b1; cpuAddr = 32'h200; cpuWdata = 32'h11;
    @(negedge coreClk);
    cpuWdata = 32'h22;
    @(negedge coreClk);
    cpuWr = 1'b0; cpuRd = 1'b1;
    #2;
    n_chk++; if (cpuStall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %0b want 0", cpuStall); end
    n_chk++; if (cpuRdata !== 32'h22) begin n_fail++; $display("FAIL fwd_data: got %0h want 22", cpuRdata); end
    n_chk++; if (vgaGnt !== 1'b1) begin n_fail++; $display("FAIL fwd_no_ram_read: got vgaGnt=%0b want 1", vgaGnt); end
    @(negedge coreClk);
    idle_inputs();
    @(negedge coreClk);
  endtask

  task automatic test_load_miss();
    do_reset();
    vgaReq = 1'b1; vgaAddr = 15'h31;
    cpuRd = 1'b1; cpuAddr = 32'hC0;
    #2;
    n_chk++; if (cpuStall !== 1'b1) begin n_fail++; $display("FAIL miss_c0_stall: got %0b want 1", cpuStall); end
    @(negedge coreClk);
    #2;
    n_chk++; if (vgaGnt !== 1'b1 || cpuStall !== 1'b1) begin n_fail++; $display("FAIL miss_lost: got vgaGnt=%0b stall=%0b want 1 1", vgaGnt, cpuStall); end
    n_chk++; if (vgaValid !== 1'b1 || vgaRdata !== 32'h66) begin n_fail++; $display("FAIL vga_data: got valid=%0b data=%0h want 1 66", vgaValid, vgaRdata); end
    @(negedge coreClk);
    #2;
    n_chk++; if (vgaGnt !== 1'b0 || vramEn !== 1'b1 || vramWe !== 1'b0 || vramAddr !== 15'h30) begin
      n_fail++; $display("FAIL miss_guard_grant: got gnt=%0b en=%0b we=%0b addr=%0h want 0 1 0 30", vgaGnt, vramEn, vramWe, vramAddr);
    end
    n_chk++; if (cpuStall !== 1'b1) begin n_fail++; $display("FAIL miss_req_stall: got %0b want 1", cpuStall); end
    @(negedge coreClk);
    #2;
    n_chk++; if (cpuStall !== 1'b0 || cpuRdata !== 32'h55) begin n_fail++; $display("FAIL miss_data: got stall=%0b data=%0h want 0 55", cpuStall, cpuRdata); end
    n_chk++; if (vgaValid !== 1'b0) begin n_fail++; $display("FAIL miss_no_vgavalid: got %0b want 0", vgaValid); end
    @(negedge coreClk);
    idle_inputs();
    @(negedge coreClk);
  endtask

  task automatic test_simul_wr_rd();
    do_reset();
    cpuWr = 1'b1; cpuRd = 1'b1; cpuAddr = 32'h300; cpuWdata = 32'h77;
    #2;
    n_chk++; if (cpuStall !== 1'b1 || vramEn !== 1'b0) begin n_fail++; $display("FAIL wrrd_first: got stall=%0b en=%0b want 1 0", cpuStall, vramEn); end
    @(negedge coreClk);
    #2;
    n_chk++; if (cpuStall !== 1'b0 || cpuRdata !== 32'h77) begin n_fail++; $display("FAIL wrrd_fwd: got stall=%0b data=%0h want 0 77", cpuStall, cpuRdata); end
    n_chk++; if (vramWe !== 1'b1 || vramAddr !== 15'hC0) begin n_fail++; $display("FAIL wrrd_drain: got we=%0b addr=%0h want 1 c0", vramWe, vramAddr); end
    @(negedge coreClk);
    idle_inputs();
    #2;
    n_chk++; if (vramEn !== 1'b0) begin n_fail++; $display("FAIL wrrd_single_entry: got %0b want 0", vramEn); end
    @(negedge coreClk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    vgaReq = 1'b1; vgaAddr = 15'h5;
    for (int i = 0; i < 3; i++) begin
      cpuWr = 1'b1; cpuAddr = 32'h80 + 32'(4 * i); cpuWdata = 32'hB0 + 32'(i);
      @(negedge coreClk);
    end
    cpuWr = 1'b0; cpuRd = 1'b1; cpuAddr = 32'h400;
    for (int i = 0; i < 3; i++) @(negedge coreClk);
    #2;
    n_chk++; if (cpuStall !== 1'b0 || cpuRdata !== 32'h09) begin n_fail++; $display("FAIL mid_in_wait: got stall=%0b data=%0h want 0 9", cpuStall, cpuRdata); end
    coreRst = 1'b0;
    #1;
    n_chk++; if ({vramEn, vramWe, vgaGnt, vgaValid, cpuStall} !== 5'b0 || cpuRdata !== 32'h0 || vgaRdata !== 32'h0 || vramAddr !== 15'h0) begin
      n_fail++; $display("FAIL mid_outputs_zero: got en=%0b we=%0b gnt=%0b vv=%0b stall=%0b rd=%0h vrd=%0h addr=%0h want all 0",
                         vramEn, vramWe, vgaGnt, vgaValid, cpuStall, cpuRdata, vgaRdata, vramAddr);
    end
    @(negedge coreClk);
    idle_inputs();
    coreRst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_chk++; if (vramEn !== 1'b0) begin n_fail++; $display("FAIL mid_no_write_after[%0d]: got en=%0b we=%0b want 0", i, vramEn, vramWe); end
      @(negedge coreClk);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    coreRst = 1'b0;
    idle_inputs();
    @(negedge coreClk);
    test_reset();
    test_post_drain();
    test_full_buffer();
    test_forwarding();
    test_load_miss();
    test_simul_wr_rd();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m32_vram_arbiter.md
# m32_vram_arbiter

Arbiter and posted-write controller that shares the single-port synchronous video RAM between the integer core's data port and the VGA scan-out fetcher. CPU VRAM stores are posted into a small write buffer and drained into idle VRAM cycles. CPU VRAM loads are forwarded from the buffer or issued to the RAM, with `cpuStall` holding the core until the data returns. VGA fetches have priority, subject to two starvation guards.

## Interface
- `ADDR_W`, 15: VRAM word-address width.
- `DATA_W`, 32: data width.
- `WBUF_DEPTH`, 4: write-buffer entries; power of two, at least 2.

- `coreClk` in 1: sole clock, rising edge.
- `coreRst` in 1: asynchronous, active-low reset.
- `cpuWr` in 1: CPU VRAM store (driven from core `wVram`).
- `cpuRd` in 1: CPU VRAM load (driven from core `rVram`).
- `cpuAddr` in 32: CPU byte address (core `maddr`). The word address is `cpuAddr[ADDR_W+1:2]`.
- `cpuWdata` in DATA_W: store data (core `data2mem`).
- `cpuRdata` out DATA_W: load data, valid in the cycle `cpuRd` is high and `cpuStall` is low.
- `cpuStall` out 1: holds the core's PC and instruction.
- `vgaReq` in 1: VGA fetch request.
- `vgaAddr` in ADDR_W: VGA word address.
- `vgaGnt` out 1: VGA request issued to the RAM this cycle.
- `vgaValid` out 1: `vgaRdata` is valid.
- `vgaRdata` out DATA_W: fetched word.
- `vramEn` out 1: RAM enable.
- `vramWe` out 1: RAM write enable.
- `vramAddr` out ADDR_W: RAM address.
- `vramWdata` out DATA_W: RAM write data.
- `vramRdata` in DATA_W: RAM read data, one-cycle latency.

## Operation
- **Write buffer:** circular FIFO of {addr, data}.
  - `cpuWr` with buffer not full: entry enqueued at the clock edge, `cpuStall`=0.
  - `cpuWr` with buffer full: `cpuStall`=1 and no enqueue. Entries freed by a same-cycle drain are not used that cycle.
- **Load forwarding:**
  - On `cpuRd`, all valid entries are compared with the word address, combinationally.
  - Hit: `cpuRdata` is the youngest matching entry's data, `cpuStall`=0, and no RAM access is made.
  - Miss: the read FSM handles the load.
- **Read FSM** (states RD_IDLE, RD_REQ, RD_WAIT):
  - RD_IDLE: `cpuRd` with a miss goes to RD_REQ with `cpuStall`=1.
  - RD_REQ: issues the read when it wins arbitration, then goes to RD_WAIT.
  - RD_WAIT: drives `cpuRdata`=`vramRdata` with `cpuStall`=0, then returns to RD_IDLE.
  - If `cpuRd` drops in RD_REQ or RD_WAIT, the FSM returns to RD_IDLE and any returned data is discarded.
- **Arbitration** (per cycle, first match wins):
  1. Buffer full and a drain is pending: drain.
  2. A CPU read that lost arbitration in the previous cycle: CPU read.
  3. `vgaReq`: VGA.
  4. RD_REQ: CPU read.
  5. Buffer not empty: drain.
  6. Otherwise idle.
- **Drain:** `vramEn`=`vramWe`=1 with the head entry; the head is popped at the clock edge.
- **Simultaneous `cpuWr` and `cpuRd`:** the write is enqueued first. The read then stalls one cycle and is forwarded from the new entry.
- **Reset:** all outputs 0, buffer empty with all pointers and count 0, FSM in RD_IDLE. Buffered writes are discarded.

## Timing
- **VGA:** granted in cycle T (`vgaGnt`=1). `vgaValid`=1 with data in T+1. Maximum extra VGA delay is 1 cycle per guard event.
- **CPU load:**
  - Forward hit: 0 stall cycles.
  - Miss: at least 1 stall cycle when uncontended; data appears in the first unstalled cycle.
- **CPU store:** 0 stall cycles unless the buffer is full.
- **Write visibility:** a store becomes visible in RAM 1 cycle after its drain is granted.
- **Full/empty:**
  - Count updates on enqueue and pop; a same-cycle enqueue and pop leaves the count unchanged.
  - Pointers wrap modulo `WBUF_DEPTH`.
  - The empty buffer never drains.

## Structure
- Package `m32_vram_pkg` holds:
  - the read-FSM state enum;
  - the grant encoding {GNT_NONE, GNT_VGA, GNT_CPURD, GNT_DRAIN};
  - default `ADDR_W`, `WBUF_DEPTH`.
- Sub-module `m32_vram_wbuf`: FIFO storage, pointers and count, full/empty flags, youngest-match lookup port.
- Top level: arbiter, read FSM, lost-arbitration flag, VRAM mux.

## Test plan
- **Post and drain:** reset; store 0xDEADBEEF to 0xC0000010 with no VGA traffic. Expect no stall, drain next cycle with `vramAddr`=4, `vramWe`=1, and the buffer empty after.
- **Full buffer:** 5 back-to-back stores with `vgaReq` held high. Expect the 5th store stalled; a forced drain in the full cycle; VGA denied exactly that cycle; store accepted next cycle.
- **Forwarding:** store 0x11 then 0x22 to the same address with the buffer blocked by VGA, then load. Expect `cpuRdata`=0x22 with zero stall.
- **Load miss under VGA load:** `vgaReq` constantly high, load of an unbuffered address holding 0x55. Expect 1 lost cycle, a guaranteed grant the next cycle, and `cpuRdata`=0x55 with stall released one cycle later.
- **Reset mid-operation:** assert `coreRst` low with 3 entries buffered and the FSM in RD_WAIT. Expect all outputs 0 immediately and no RAM write after release.
